// File: rtl/mux_scanner.sv
// -----------------------------------------------------------------------------
// mux_scanner
//
// N-channel data selector with a registered, flag-gated output. In manual
// mode the channel comes from `sel`. In scan mode the channel advances
// round-robin after DWELL enabled cycles on each channel. The active channel
// index is reported on cur_ch, and ch_tick pulses for one cycle whenever it
// changes.
//
// Optional build macro: SCAN_MASK_EN
//   When defined, the module gains a ch_mask input (1 = channel enabled).
//   - Scan advance skips disabled channels.
//   - An all-zero mask freezes scanning.
//   - Selecting a disabled channel forces valid_data to 0.
//   When undefined, every channel is treated as enabled.
//
// Ports:
//   clk        rising-edge system clock
//   rst        synchronous reset, active-high
//   data       CH_NUM*DATA_W channel bus, channel k at [k*DATA_W +: DATA_W]
//   sel        manual channel select
//   flag       output enable / scan run
//   scan       1 = auto-scan mode, 0 = manual mode
//   ch_mask    (SCAN_MASK_EN only) per-channel enable
//   valid_data registered selected data, 0 when gated off
//   cur_ch     registered active channel index
//   ch_tick    one-cycle pulse when cur_ch changes
// -----------------------------------------------------------------------------
module mux_scanner #(
    parameter int CH_NUM = 4,
    parameter int DATA_W = 1,
    parameter int SEL_W  = 2,
    parameter int DWELL  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CH_NUM*DATA_W-1:0] data,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     flag,
    input  logic                     scan,
`ifdef SCAN_MASK_EN
    input  logic [CH_NUM-1:0]        ch_mask,
`endif
    output logic [DATA_W-1:0]        valid_data,
    output logic [SEL_W-1:0]         cur_ch,
    output logic                     ch_tick
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W:0]   CH_NUM_W = (SEL_W + 1)'(CH_NUM);

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } mode_e;

    mode_e              mode;
    logic [CH_NUM-1:0]  ch_en;
    logic [DATA_W-1:0]  data_arr [CH_NUM];

    logic [SEL_W-1:0]   cur_ch_reg,     cur_ch_next;
    logic [CNT_W-1:0]   cnt_reg,        cnt_next;
    logic [DATA_W-1:0]  valid_data_reg, valid_data_next;
    logic               ch_tick_reg,    ch_tick_next;

    logic [SEL_W-1:0]   adv_ch;
    logic               adv_found;
    logic [SEL_W:0]     probe;

`ifdef SCAN_MASK_EN
    assign ch_en = ch_mask;
`else
    assign ch_en = '1;
`endif

    // Unpack the flat channel bus so the mux can be indexed by channel number.
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_unpack
        assign data_arr[gi] = data[gi*DATA_W +: DATA_W];
    end

    // Nearest enabled channel above cur_ch, wrapping modulo CH_NUM.
    // If no other channel is enabled, the current channel is kept.
    always_comb begin
        adv_ch    = cur_ch_reg;
        adv_found = 1'b0;
        probe     = '0;
        for (int k = 1; k < CH_NUM; k++) begin
            probe = {1'b0, cur_ch_reg} + (SEL_W + 1)'(k);
            if (probe >= CH_NUM_W) begin
                probe = probe - CH_NUM_W;
            end
            if (!adv_found && ch_en[probe[SEL_W-1:0]]) begin
                adv_ch    = probe[SEL_W-1:0];
                adv_found = 1'b1;
            end
        end
    end

    // Mode takes effect on the same edge it is sampled.
    // The default dwell counter value of 0 means a scan entered from manual
    // mode gives the current channel a full DWELL.
    always_comb begin
        mode            = scan ? SCAN : MANUAL;
        cur_ch_next     = cur_ch_reg;
        cnt_next        = cnt_reg;
        valid_data_next = '0;
        ch_tick_next    = 1'b0;

        case (mode)
            MANUAL: begin
                cnt_next = '0;
                if ({1'b0, sel} < CH_NUM_W) begin
                    cur_ch_next = sel;
                end
            end
            SCAN: begin
                // An all-zero mask is treated like a pause. The hold below
                // also gates valid_data, since ch_en[cur_ch] is 0.
                if (flag && (ch_en != '0)) begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_next    = '0;
                        cur_ch_next = adv_ch;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            default: begin
                cnt_next = '0;
            end
        endcase

        // Output data is taken from the channel being loaded this edge, so
        // valid_data and cur_ch always refer to the same channel.
        if (flag && ch_en[cur_ch_next]) begin
            valid_data_next = data_arr[cur_ch_next];
        end
        ch_tick_next = (cur_ch_next != cur_ch_reg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_ch_reg     <= '0;
            cnt_reg        <= '0;
            valid_data_reg <= '0;
            ch_tick_reg    <= 1'b0;
        end else begin
            cur_ch_reg     <= cur_ch_next;
            cnt_reg        <= cnt_next;
            valid_data_reg <= valid_data_next;
            ch_tick_reg    <= ch_tick_next;
        end
    end

    assign valid_data = valid_data_reg;
    assign cur_ch     = cur_ch_reg;
    assign ch_tick    = ch_tick_reg;

endmodule
